// File: rtl/regfile.sv
// 32 x 32-bit register file: one write port (write-back), two combinational read ports (decode).
// Define REGFILE_BYPASS_EN to forward the write-back value to a same-cycle read of that register.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              hit1;
   logic              hit2;

   // NOTE: the whole array is cleared asynchronously, so it must be built from flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign hit1 = we && (waddr == raddr1);
   assign hit2 = we && (waddr == raddr2);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   // NOTE: each output gets a default before the priority chain, so no latch can be inferred.
   always_comb begin
      rdata1 = regs[raddr1];
      if (!rst || (raddr1 == '0) || !re1) begin
         rdata1 = '0;
      end else if (hit1) begin
         rdata1 = wdata;
      end

      rdata2 = regs[raddr2];
      if (!rst || (raddr2 == '0) || !re2) begin
         rdata2 = '0;
      end else if (hit2) begin
         rdata2 = wdata;
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow the REGFILE_BYPASS_EN build setting.
module tb_regfile;
   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;

   int vectors     = 0;
   int miscompares = 0;

   regfile dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Called 1 time unit after a rising edge; commits at the next edge and returns 1 unit after it.
   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      we    = 1'b1;
      waddr = addr;
      wdata = data;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      re1    = 1'b1;
      raddr1 = a1;
      re2    = 1'b1;
      raddr2 = a2;
      #1;
   endtask

   initial begin
      logic [31:0] exp_val;

      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

      // Reset: a write attempted while rst is low must be ignored.
      #2;
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      #1;
      check("reset_rd1", rdata1, 32'h0);
      check("reset_rd2", rdata2, 32'h0);
      @(posedge clk);
      #1;
      check("reset_edge_rd1", rdata1, 32'h0);
      check("reset_edge_rd2", rdata2, 32'h0);
      @(negedge clk);
      we  = 1'b0;
      rst = 1'b1;
      #1;
      check("post_reset_r5", rdata1, 32'h0);
      @(posedge clk);
      #1;

      // Basic write / read on both ports, then read-enable gating.
      wr(5'd3, 32'h12345678);
      rd(5'd3, 5'd3);
      check("basic_rd1", rdata1, 32'h12345678);
      check("basic_rd2", rdata2, 32'h12345678);
      re2 = 1'b0;
      #1;
      check("re2_off", rdata2, 32'h0);
      re1 = 1'b0;
      #1;
      check("re1_off", rdata1, 32'h0);

      // Register 0 is never written and always reads zero, even with a same-cycle write.
      wr(5'd0, 32'hFFFFFFFF);
      rd(5'd0, 5'd0);
      check("r0_rd1", rdata1, 32'h0);
      check("r0_rd2", rdata2, 32'h0);
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
      #1;
      check("r0_bypass_rd1", rdata1, 32'h0);
      check("r0_bypass_rd2", rdata2, 32'h0);
      @(posedge clk);
      #1;
      we = 1'b0;

      // Same-cycle write/read hazard on r7.
      wr(5'd7, 32'h00000011);
      rd(5'd7, 5'd7);
      check("r7_before", rdata1, 32'h00000011);
      we = 1'b1; waddr = 5'd7; wdata = 32'h00000022;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_val = 32'h00000022;
`else
      exp_val = 32'h00000011;
`endif
      check("hazard_rd1", rdata1, exp_val);
      check("hazard_rd2", rdata2, exp_val);
      re2 = 1'b0;
      #1;
      check("hazard_re2_off", rdata2, 32'h0);
      @(posedge clk);
      #1;
      we = 1'b0;
      re2 = 1'b1;
      #1;
      check("hazard_after_rd1", rdata1, 32'h00000022);
      check("hazard_after_rd2", rdata2, 32'h00000022);

      // Asynchronous reset between edges clears storage immediately.
      wr(5'd9, 32'hA5A5A5A5);
      rd(5'd9, 5'd3);
      check("r9_written", rdata1, 32'hA5A5A5A5);
      check("r3_still", rdata2, 32'h12345678);
      #1;
      rst = 1'b0;
      #1;
      check("async_rst_r9", rdata1, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("after_rst_r9", rdata1, 32'h0);
      check("after_rst_r3", rdata2, 32'h0);
      @(posedge clk);
      #1;

      // Sweep every register through both ports.
      for (int i = 1; i < 32; i++) begin
         wr(5'(i), 32'(i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         exp_val = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
         check($sformatf("sweep_rd1_r%0d", i), rdata1, exp_val);
         exp_val = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101;
         check($sformatf("sweep_rd2_r%0d", 31 - i), rdata2, exp_val);
      end

      // Back-to-back writes to one index: the later one wins.
      wr(5'd4, 32'h00000001);
      wr(5'd4, 32'h00000002);
      rd(5'd4, 5'd4);
      check("b2b_rd1", rdata1, 32'h00000002);
      check("b2b_rd2", rdata2, 32'h00000002);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
